// File: rtl/store_buffer_pkg.sv
// Shared constants and types for the store buffer between the MEM stage and data_memory.
package store_buffer_pkg;

   localparam int SB_DEPTH    = 4;
   localparam int BYTE_MASK_W = 4;

   localparam logic [2:0] FUNCT3_SB  = 3'b000;
   localparam logic [2:0] FUNCT3_SH  = 3'b001;
   localparam logic [2:0] FUNCT3_SW  = 3'b010;
   localparam logic [2:0] FUNCT3_LB  = 3'b000;
   localparam logic [2:0] FUNCT3_LH  = 3'b001;
   localparam logic [2:0] FUNCT3_LW  = 3'b010;
   localparam logic [2:0] FUNCT3_LBU = 3'b100;
   localparam logic [2:0] FUNCT3_LHU = 3'b101;

   typedef enum logic [1:0] {
      PORT_IDLE  = 2'b00,
      PORT_LOAD  = 2'b01,
      PORT_DRAIN = 2'b10
   } port_sel_e;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic [2:0]  funct3;
   } sb_entry_t;

endpackage

// File: rtl/sb_byte_mask.sv
// Byte-lane footprint of a load or store within its 32-bit word.
module sb_byte_mask
   import store_buffer_pkg::*;
(
   input  logic [2:0]             funct3,
   input  logic [1:0]             addr_lo,
   output logic [BYTE_MASK_W-1:0] mask
);

   // Access size depends only on funct3[1:0]; the unsigned bit does not change the footprint
   always_comb begin
      mask = 4'b0000;
      case (funct3[1:0])
         2'b00:   mask = 4'b0001 << addr_lo;
         2'b01:   mask = 4'b0011 << {addr_lo[1], 1'b0};
         2'b10:   mask = 4'b1111;
         default: mask = 4'b1111;
      endcase
   end

endmodule

// File: rtl/store_buffer.sv
// FIFO write buffer that drains stores to data_memory whenever a load does not own the port,
// stalling any load whose bytes overlap a queued store.
module store_buffer
   import store_buffer_pkg::*;
#(
   parameter int DEPTH = SB_DEPTH,
   parameter int PTR_W = $clog2(DEPTH)
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        st_valid_i,
   input  logic [31:0] st_addr_i,
   input  logic [31:0] st_data_i,
   input  logic [2:0]  st_funct3_i,
   output logic        st_ready_o,
   input  logic        ld_en_i,
   input  logic [31:0] ld_addr_i,
   input  logic [2:0]  ld_funct3_i,
   output logic        ld_stall_o,
   output logic        mem_read_en_o,
   output logic        mem_write_en_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   output logic [2:0]  mem_funct3_o,
   output logic        empty_o
);

   localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
   localparam logic [PTR_W:0]   ZERO_CNT = (PTR_W + 1)'(0);
   localparam logic [PTR_W:0]   ONE_CNT  = (PTR_W + 1)'(1);
   localparam logic [PTR_W-1:0] ZERO_PTR = PTR_W'(0);
   localparam logic [PTR_W-1:0] ONE_PTR  = PTR_W'(1);

   sb_entry_t              entry_r [DEPTH];
   logic [PTR_W-1:0]       wr_ptr_r;
   logic [PTR_W-1:0]       rd_ptr_r;
   logic [PTR_W:0]         count_r;

   logic [BYTE_MASK_W-1:0] entry_mask_s [DEPTH];
   logic [DEPTH-1:0]       entry_valid_s;
   logic [DEPTH-1:0]       entry_hit_s;
   logic [BYTE_MASK_W-1:0] ld_mask_s;
   logic                   push_s;
   logic                   pop_s;
   port_sel_e              port_sel_s;
   sb_entry_t              head_s;

   sb_byte_mask u_ld_mask (
      .funct3  (ld_funct3_i),
      .addr_lo (ld_addr_i[1:0]),
      .mask    (ld_mask_s)
   );

   // An entry is live when its distance from the head is below the occupancy count
   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_entry
         logic [PTR_W-1:0] offset_s;

         sb_byte_mask u_entry_mask (
            .funct3  (entry_r[gi].funct3),
            .addr_lo (entry_r[gi].addr[1:0]),
            .mask    (entry_mask_s[gi])
         );

         assign offset_s           = PTR_W'(gi) - rd_ptr_r;
         assign entry_valid_s[gi]  = ({1'b0, offset_s} < count_r);
         assign entry_hit_s[gi]    = entry_valid_s[gi]
                                  && (entry_r[gi].addr[31:2] == ld_addr_i[31:2])
                                  && ((entry_mask_s[gi] & ld_mask_s) != 4'b0000);
      end
   endgenerate

   assign ld_stall_o = ld_en_i && (entry_hit_s != {DEPTH{1'b0}});
   assign st_ready_o = (count_r != FULL_CNT);
   assign empty_o    = (count_r == ZERO_CNT);
   assign head_s     = entry_r[rd_ptr_r];
   assign push_s     = st_valid_i && st_ready_o;
   assign pop_s      = (port_sel_s == PORT_DRAIN);

   // Port owner: an unstalled load wins, otherwise drain the head if anything is queued
   always_comb begin
      port_sel_s = PORT_IDLE;
      if (ld_en_i && !ld_stall_o) begin
         port_sel_s = PORT_LOAD;
      end else if (!empty_o) begin
         port_sel_s = PORT_DRAIN;
      end else begin
         port_sel_s = PORT_IDLE;
      end
   end

   // Drive data_memory from the selected owner; idle cycles present all zeros
   always_comb begin
      mem_read_en_o  = 1'b0;
      mem_write_en_o = 1'b0;
      mem_addr_o     = 32'h0000_0000;
      mem_wdata_o    = 32'h0000_0000;
      mem_funct3_o   = 3'b000;
      case (port_sel_s)
         PORT_LOAD: begin
            mem_read_en_o = 1'b1;
            mem_addr_o    = ld_addr_i;
            mem_funct3_o  = ld_funct3_i;
         end
         PORT_DRAIN: begin
            mem_write_en_o = 1'b1;
            mem_addr_o     = head_s.addr;
            mem_wdata_o    = head_s.data;
            mem_funct3_o   = head_s.funct3;
         end
         PORT_IDLE: begin
            mem_read_en_o  = 1'b0;
            mem_write_en_o = 1'b0;
         end
         default: begin
            mem_read_en_o  = 1'b0;
            mem_write_en_o = 1'b0;
         end
      endcase
   end

   // Pointer and occupancy bookkeeping; reset discards every queued store
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_r <= ZERO_PTR;
         rd_ptr_r <= ZERO_PTR;
         count_r  <= ZERO_CNT;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + ONE_PTR;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + ONE_PTR;
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + ONE_CNT;
            2'b01:   count_r <= count_r - ONE_CNT;
            default: count_r <= count_r;
         endcase
      end
   end

   // Entry payload needs no reset; liveness comes from the pointers and count
   always_ff @(posedge clk) begin
      if (push_s) begin
         entry_r[wr_ptr_r] <= {st_addr_i, st_data_i, st_funct3_i};
      end
   end

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: a queue-based model predicts each cycle, a monitor compares.
module tb_store_buffer;
   import store_buffer_pkg::*;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        st_valid_i;
   logic [31:0] st_addr_i;
   logic [31:0] st_data_i;
   logic [2:0]  st_funct3_i;
   logic        st_ready_o;
   logic        ld_en_i;
   logic [31:0] ld_addr_i;
   logic [2:0]  ld_funct3_i;
   logic        ld_stall_o;
   logic        mem_read_en_o;
   logic        mem_write_en_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic [2:0]  mem_funct3_o;
   logic        empty_o;

   store_buffer #(.DEPTH(DEPTH)) dut (
      .clk            (clk),
      .rst            (rst),
      .st_valid_i     (st_valid_i),
      .st_addr_i      (st_addr_i),
      .st_data_i      (st_data_i),
      .st_funct3_i    (st_funct3_i),
      .st_ready_o     (st_ready_o),
      .ld_en_i        (ld_en_i),
      .ld_addr_i      (ld_addr_i),
      .ld_funct3_i    (ld_funct3_i),
      .ld_stall_o     (ld_stall_o),
      .mem_read_en_o  (mem_read_en_o),
      .mem_write_en_o (mem_write_en_o),
      .mem_addr_o     (mem_addr_o),
      .mem_wdata_o    (mem_wdata_o),
      .mem_funct3_o   (mem_funct3_o),
      .empty_o        (empty_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [2:0]  f;
   } st_t;

   typedef struct {
      bit          ready;
      bit          stall;
      bit          empty;
      bit          rd;
      bit          wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [2:0]  f;
   } cyc_t;

   st_t         mq[$];
   st_t         wr_q[$];
   cyc_t        exp_q[$];
   logic [7:0]  refmem [256];
   logic [7:0]  dmem [256];
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] last_rd = 32'h0;
   st_t         pend_st;
   bit          pend_v = 1'b0;

   function automatic int nbytes(input logic [2:0] f);
      if (f[1:0] == 2'b00) return 1;
      else if (f[1:0] == 2'b01) return 2;
      else return 4;
   endfunction

   function automatic bit overlap(input logic [31:0] a, input int na, input logic [31:0] b, input int nb);
      longint lo_a = longint'(a);
      longint lo_b = longint'(b);
      return (lo_a < lo_b + nb) && (lo_b < lo_a + na);
   endfunction

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endfunction

   // One clock cycle of stimulus; the model predicts this cycle's outputs and updates its queue
   task automatic step(input bit sv, input logic [31:0] sa, input logic [31:0] sd, input logic [2:0] sf,
                       input bit le, input logic [31:0] la, input logic [2:0] lf);
      cyc_t e;
      st_t  s;
      bit   stall = 1'b0;
      if (pend_v) begin
         for (int k = 0; k < nbytes(pend_st.f); k++)
            refmem[int'(pend_st.addr[7:0]) + k] = pend_st.data[8*k +: 8];
         pend_v = 1'b0;
      end
      st_valid_i = sv; st_addr_i = sa; st_data_i = sd; st_funct3_i = sf;
      ld_en_i = le; ld_addr_i = la; ld_funct3_i = lf;
      foreach (mq[i])
         if (le && overlap(mq[i].addr, nbytes(mq[i].f), la, nbytes(lf))) stall = 1'b1;
      e = '{default: 0};
      e.ready = (mq.size() < DEPTH);
      e.empty = (mq.size() == 0);
      e.stall = stall;
      if (le && !stall) begin
         e.rd = 1'b1; e.addr = la; e.f = lf;
      end else if (mq.size() > 0) begin
         e.wr = 1'b1; e.addr = mq[0].addr; e.wdata = mq[0].data; e.f = mq[0].f;
      end
      if (e.wr) mq.delete(0);
      if (sv && e.ready) begin
         s = '{sa, sd, sf};
         mq.push_back(s);
         wr_q.push_back(s);
         pend_st = s;
         pend_v  = 1'b1;
      end
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 32'h0, 32'h0, 3'b000, 1'b0, 32'h0, 3'b000);
   endtask

   // Monitor: per-cycle expectations, FIFO order of drained stores, and load coherence
   always @(negedge clk) begin
      cyc_t e;
      st_t  s;
      int   a;
      if (!rst) begin
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("st_ready", {31'h0, st_ready_o}, {31'h0, e.ready});
            chk("ld_stall", {31'h0, ld_stall_o}, {31'h0, e.stall});
            chk("empty", {31'h0, empty_o}, {31'h0, e.empty});
            chk("read_en", {31'h0, mem_read_en_o}, {31'h0, e.rd});
            chk("write_en", {31'h0, mem_write_en_o}, {31'h0, e.wr});
            chk("mem_addr", mem_addr_o, e.addr);
            chk("mem_funct3", {29'h0, mem_funct3_o}, {29'h0, e.f});
            if (!e.rd) chk("mem_wdata", mem_wdata_o, e.wdata);
         end
         if (mem_read_en_o) begin
            for (int k = 0; k < nbytes(mem_funct3_o); k++) begin
               a = int'(mem_addr_o[7:0]) + k;
               if (a < 256) chk("ld_coherent", {24'h0, dmem[a]}, {24'h0, refmem[a]});
            end
            a = int'({mem_addr_o[7:2], 2'b00});
            last_rd = {dmem[a+3], dmem[a+2], dmem[a+1], dmem[a]};
         end
         if (mem_write_en_o) begin
            if (wr_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL wr_order: unexpected write addr 0x%0h data 0x%0h", mem_addr_o, mem_wdata_o);
            end else begin
               s = wr_q.pop_front();
               chk("wr_order_addr", mem_addr_o, s.addr);
               chk("wr_order_data", mem_wdata_o, s.data);
               chk("wr_order_f3", {29'h0, mem_funct3_o}, {29'h0, s.f});
            end
            for (int k = 0; k < nbytes(mem_funct3_o); k++) begin
               a = int'(mem_addr_o[7:0]) + k;
               if (a < 256) dmem[a] = mem_wdata_o[8*k +: 8];
            end
         end
      end
   end

   logic [2:0] ld_codes [5];
   logic [31:0] ra;
   logic [31:0] la;
   logic [2:0]  rf;
   logic [2:0]  lf;

   initial begin
      ld_codes = '{FUNCT3_LB, FUNCT3_LH, FUNCT3_LW, FUNCT3_LBU, FUNCT3_LHU};
      foreach (dmem[i]) begin dmem[i] = 8'h00; refmem[i] = 8'h00; end
      rst = 1'b1;
      st_valid_i = 1'b0; st_addr_i = 32'h0; st_data_i = 32'h0; st_funct3_i = 3'b000;
      ld_en_i = 1'b0; ld_addr_i = 32'h0; ld_funct3_i = 3'b000;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", {31'h0, st_ready_o}, 32'h1);
      chk("rst_empty", {31'h0, empty_o}, 32'h1);
      chk("rst_write_en", {31'h0, mem_write_en_o}, 32'h0);
      chk("rst_stall", {31'h0, ld_stall_o}, 32'h0);
      ld_en_i = 1'b1; ld_addr_i = 32'h40; ld_funct3_i = FUNCT3_LW;
      #1;
      chk("rst_read_follow", {31'h0, mem_read_en_o}, 32'h1);
      ld_en_i = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Single SW, drained the next cycle
      step(1'b1, 32'h10, 32'hCAFEBABE, FUNCT3_SW, 1'b0, 32'h0, 3'b000);
      idle(1);
      chk("t1_empty_after", {31'h0, empty_o}, 32'h1);
      chk("t1_mem_word", {dmem[8'h13], dmem[8'h12], dmem[8'h11], dmem[8'h10]}, 32'hCAFEBABE);

      // Fill while a non-overlapping load holds the port, hold a 5th, then release
      for (int i = 0; i < 4; i++)
         step(1'b1, 32'(i * 4), $urandom, FUNCT3_SW, 1'b1, 32'h80, FUNCT3_LW);
      chk("t2_full_ready", {31'h0, st_ready_o}, 32'h0);
      step(1'b1, 32'h14, 32'h5555AAAA, FUNCT3_SW, 1'b1, 32'h80, FUNCT3_LW);
      step(1'b1, 32'h14, 32'h5555AAAA, FUNCT3_SW, 1'b0, 32'h0, 3'b000);
      idle(6);

      // SB 0x21 then LW 0x20: stalled until drained, then reads the merged word
      step(1'b1, 32'h21, 32'h0000005A, FUNCT3_SB, 1'b0, 32'h0, 3'b000);
      for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 32'h0, 3'b000, 1'b1, 32'h20, FUNCT3_LW);
      chk("t3_load_data", last_rd, 32'h00005A00);

      // SH 0x40 then LBU 0x43: disjoint bytes, load goes first
      step(1'b1, 32'h40, 32'h0000BEEF, FUNCT3_SH, 1'b0, 32'h0, 3'b000);
      step(1'b0, 32'h0, 32'h0, 3'b000, 1'b1, 32'h43, FUNCT3_LBU);
      idle(3);

      // Full buffer: drain cycle refuses a store, next cycle accepts it back to full
      for (int i = 0; i < 4; i++)
         step(1'b1, 32'(32'h60 + i * 4), $urandom, FUNCT3_SW, 1'b1, 32'h80, FUNCT3_LW);
      step(1'b1, 32'h70, 32'h12345678, FUNCT3_SW, 1'b0, 32'h0, 3'b000);
      step(1'b1, 32'h70, 32'h12345678, FUNCT3_SW, 1'b1, 32'h80, FUNCT3_LW);
      chk("t5_full_again", {31'h0, st_ready_o}, 32'h0);
      idle(6);

      // Reset with three queued stores discards them
      for (int i = 0; i < 3; i++)
         step(1'b1, 32'(32'h90 + i * 4), $urandom, FUNCT3_SW, 1'b1, 32'h80, FUNCT3_LW);
      ld_en_i = 1'b0; st_valid_i = 1'b0;
      rst = 1'b1;
      #1;
      chk("t6_rst_empty", {31'h0, empty_o}, 32'h1);
      chk("t6_rst_ready", {31'h0, st_ready_o}, 32'h1);
      chk("t6_rst_write_en", {31'h0, mem_write_en_o}, 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      mq.delete();
      wr_q.delete();
      pend_v = 1'b0;
      foreach (refmem[i]) refmem[i] = dmem[i];
      idle(4);

      // Random traffic in a small window so overlaps are frequent
      for (int i = 0; i < 500; i++) begin
         rf = 3'($urandom_range(0, 2));
         ra = 32'($urandom_range(0, 7) * 4);
         if (rf == FUNCT3_SB) ra = ra + 32'($urandom_range(0, 3));
         else if (rf == FUNCT3_SH) ra = ra + 32'($urandom_range(0, 1) * 2);
         lf = ld_codes[$urandom_range(0, 4)];
         la = 32'($urandom_range(0, 7) * 4);
         if (lf[1:0] == 2'b00) la = la + 32'($urandom_range(0, 3));
         else if (lf[1:0] == 2'b01) la = la + 32'($urandom_range(0, 1) * 2);
         step(($urandom % 2) == 0, ra, $urandom, rf, ($urandom % 3) == 0, la, lf);
      end
      idle(DEPTH + 4);
      chk("final_drained", 32'(wr_q.size()), 32'h0);
      chk("final_empty", {31'h0, empty_o}, 32'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
